// File: rtl/ovl_stim_pkg.sv
// Shared types and constants for the unchange-checker stimulus generator.
package ovl_stim_pkg;

  // Upper bounds for the command payload; the generator zero-extends into these.
  localparam int unsigned VALUE_MAX_W = 64;
  localparam int unsigned CYCLE_MAX_W = 8;
  localparam int unsigned GAP_MAX_W   = 16;

  // Same encoding as OVL_IGNORE_NEW_START / OVL_RESET_ON_NEW_START / OVL_ERROR_ON_NEW_START.
  localparam int unsigned IGNORE = 0;
  localparam int unsigned RESET  = 1;
  localparam int unsigned ERROR  = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_HOLD,
    ST_GAP
  } state_t;

  typedef struct packed {
    logic [VALUE_MAX_W-1:0] value;
    logic                   inject_change;
    logic                   restart;
    logic [CYCLE_MAX_W-1:0] inject_cycle;
    logic [GAP_MAX_W-1:0]   gap;
  } cmd_t;

endpackage

// File: rtl/ovl_stim_down_counter.sv
// Loadable down-counter that saturates at zero; zero flag is registered alongside the count.
module ovl_stim_down_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic [W-1:0] count_next_c,
  output logic         zero
);

  always_comb begin
    count_next_c = count;
    if (load) begin
      count_next_c = load_value;
    end else if (dec && (count != '0)) begin
      count_next_c = count - W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      zero  <= 1'b1;
    end else begin
      count <= count_next_c;
      zero  <= (count_next_c == '0);
    end
  end

endmodule

// File: rtl/ovl_unchange_stim_gen.sv
// Drives start_event/test_expr for an unchange checker, one command per window,
// and flags the cycles in which a correct checker must fire.
module ovl_unchange_stim_gen
  import ovl_stim_pkg::*;
#(
  parameter int unsigned width               = 8,
  parameter int unsigned num_cks             = 2,
  parameter int unsigned action_on_new_start = 0,
  parameter int unsigned max_gap             = 15,
  localparam int unsigned CW = $clog2(num_cks + 1),
  localparam int unsigned GW = $clog2(max_gap + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [width-1:0] cmd_value,
  input  logic             cmd_inject_change,
  input  logic             cmd_restart,
  input  logic [CW-1:0]    cmd_inject_cycle,
  input  logic [GW-1:0]    cmd_gap,
  output logic             start_event,
  output logic [width-1:0] test_expr,
  output logic             exp_fire,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = (CW > GW) ? CW : GW;
  // Remaining-count encoding: window cycle k = num_cks - count, so k=1 loads num_cks-1.
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(num_cks - 32'd1);

  state_t           state_q, state_n;
  cmd_t             cmd_q, cmd_n, cmd_in;
  logic             fired_q, fired_n;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_load_value, cnt_q, cnt_n;
  logic             hit_now, hit_next, window_end;
  logic             cmd_ready_d, start_event_d, exp_fire_d, busy_d, done_d;
  logic [width-1:0] test_expr_d;
  logic             unused_cmd;

  // Injection point reached and not yet used by this command.
  function automatic logic is_hit(input logic [CNT_W-1:0]       rem,
                                  input logic [CYCLE_MAX_W-1:0] cycle,
                                  input logic                   fired);
    int unsigned k;
    k = num_cks - 32'(rem);
    return !fired && (cycle != '0) && (k == 32'(cycle));
  endfunction

  always_comb begin
    cmd_in               = '0;
    cmd_in.value         = VALUE_MAX_W'(cmd_value);
    cmd_in.inject_change = cmd_inject_change;
    cmd_in.restart       = cmd_restart;
    cmd_in.inject_cycle  = CYCLE_MAX_W'(cmd_inject_cycle);
    cmd_in.gap           = GAP_MAX_W'(cmd_gap);
  end

  // Upper payload bits are always zero; fold them so every bit has a reader.
  assign unused_cmd = ^cmd_q;

  ovl_stim_down_counter #(.W(CNT_W)) u_cnt (
    .clk          (clk),
    .reset_n      (reset_n),
    .load         (cnt_load),
    .load_value   (cnt_load_value),
    .dec          (cnt_dec),
    .count        (cnt_q),
    .count_next_c (cnt_n),
    .zero         (cnt_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      fired_q <= 1'b0;
    end else begin
      state_q <= state_n;
      cmd_q   <= cmd_n;
      fired_q <= fired_n;
    end
  end

  always_comb begin
    state_n        = state_q;
    cmd_n          = cmd_q;
    fired_n        = fired_q;
    cnt_load       = 1'b0;
    cnt_dec        = 1'b0;
    cnt_load_value = HOLD_LOAD;
    window_end     = 1'b0;
    hit_now        = is_hit(cnt_q, cmd_q.inject_cycle, fired_q);
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_n = ST_START;
          cmd_n   = cmd_in;
          fired_n = 1'b0;
        end
      end
      ST_START: begin
        cnt_load = 1'b1;
        state_n  = ST_HOLD;
      end
      ST_HOLD: begin
        fired_n = fired_q | hit_now;
        if (hit_now && cmd_q.restart && (action_on_new_start == RESET)) begin
          cnt_load = 1'b1;
        end else if (cnt_zero) begin
          window_end = 1'b1;
          if (cmd_q.gap != '0) begin
            cnt_load       = 1'b1;
            cnt_load_value = CNT_W'(cmd_q.gap - GAP_MAX_W'(1));
            state_n        = ST_GAP;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_zero) begin
          state_n = ST_IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Outputs are decoded from next-cycle state so they land in the register aligned to it.
  always_comb begin
    cmd_ready_d   = (state_n == ST_IDLE);
    busy_d        = (state_n != ST_IDLE);
    done_d        = window_end;
    start_event_d = 1'b0;
    exp_fire_d    = 1'b0;
    test_expr_d   = test_expr;
    hit_next      = is_hit(cnt_n, cmd_n.inject_cycle, fired_n);
    unique case (state_n)
      ST_START: begin
        start_event_d = 1'b1;
        test_expr_d   = cmd_n.value[width-1:0];
      end
      ST_HOLD: begin
        start_event_d = hit_next && cmd_n.restart;
        exp_fire_d    = hit_next && (cmd_n.inject_change ||
                                     (cmd_n.restart && (action_on_new_start == ERROR)));
        test_expr_d   = ((fired_n || hit_next) && cmd_n.inject_change) ?
                        ~cmd_n.value[width-1:0] : cmd_n.value[width-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_ready   <= 1'b0;
      start_event <= 1'b0;
      test_expr   <= '0;
      exp_fire    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      cmd_ready   <= cmd_ready_d;
      start_event <= start_event_d;
      test_expr   <= test_expr_d;
      exp_fire    <= exp_fire_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

endmodule

// File: tb/tb_ovl_unchange_stim_gen.sv
// Directed bench: five generator instances covering window lengths 2/3/4 and all new-start actions.
module tb_ovl_unchange_stim_gen;

  localparam int NDUT = 5;

  // Instance map: 0:num_cks=2 act0, 1:num_cks=4 act0, 2:num_cks=3 act1, 3:num_cks=3 act2, 4:num_cks=3 act0
  function automatic int unsigned nck_of(input int g);
    case (g)
      0:       return 2;
      1:       return 4;
      default: return 3;
    endcase
  endfunction

  function automatic int unsigned act_of(input int g);
    case (g)
      2:       return 1;
      3:       return 2;
      default: return 0;
    endcase
  endfunction

  logic            clk;
  logic            reset_n;
  logic [NDUT-1:0] vld, rdy, se, ef, bz, dn;
  logic [7:0]      te [NDUT];
  logic [7:0]      cmd_value;
  logic            cmd_chg, cmd_rst;
  logic [2:0]      cmd_ic;
  logic [3:0]      cmd_gap;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] se_t, ef_t, dn_t, bz_t, rd_t;
  logic [7:0]  te_t [12];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned NCK = nck_of(g);
    localparam int unsigned CWG = $clog2(NCK + 1);
    ovl_unchange_stim_gen #(
      .width               (8),
      .num_cks             (NCK),
      .action_on_new_start (act_of(g)),
      .max_gap             (15)
    ) u_dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .cmd_valid         (vld[g]),
      .cmd_ready         (rdy[g]),
      .cmd_value         (cmd_value),
      .cmd_inject_change (cmd_chg),
      .cmd_restart       (cmd_rst),
      .cmd_inject_cycle  (cmd_ic[CWG-1:0]),
      .cmd_gap           (cmd_gap),
      .start_event       (se[g]),
      .test_expr         (te[g]),
      .exp_fire          (ef[g]),
      .busy              (bz[g]),
      .done              (dn[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input int idx);
    for (int i = 0; i < 30 && !rdy[idx]; i++) begin
      @(posedge clk); #1;
    end
    check("cmd_ready_seen", 32'(rdy[idx]), 32'd1);
  endtask

  // Returns #1 after the accepting edge, i.e. in the START cycle.
  task automatic send(input int idx, input logic [7:0] value, input logic chg,
                      input logic rst, input logic [2:0] ic, input logic [3:0] gap,
                      input bit hold_valid);
    wait_ready(idx);
    cmd_value = value;
    cmd_chg   = chg;
    cmd_rst   = rst;
    cmd_ic    = ic;
    cmd_gap   = gap;
    vld[idx]  = 1'b1;
    @(posedge clk); #1;
    if (!hold_valid) vld[idx] = 1'b0;
  endtask

  // Records 12 cycles of outputs; bit c of each trace is cycle c after the accept (c=0 is START).
  task automatic capture(input int idx, input bit b2b);
    se_t = '0; ef_t = '0; dn_t = '0; bz_t = '0; rd_t = '0;
    for (int c = 0; c < 12; c++) begin
      se_t[c] = se[idx];
      ef_t[c] = ef[idx];
      dn_t[c] = dn[idx];
      bz_t[c] = bz[idx];
      rd_t[c] = rdy[idx];
      te_t[c] = te[idx];
      if (b2b) begin
        if (c == 0) begin
          cmd_value = 8'h22;
          cmd_gap   = 4'd0;
        end else if (se[idx]) begin
          vld[idx] = 1'b0;
        end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    vld       = '0;
    cmd_value = '0;
    cmd_chg   = 1'b0;
    cmd_rst   = 1'b0;
    cmd_ic    = '0;
    cmd_gap   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ctrl_outputs", 32'({se, ef, bz, dn}), 32'd0);
    check("rst_cmd_ready", 32'(rdy), 32'd0);
    for (int g = 0; g < NDUT; g++) check("rst_test_expr", 32'(te[g]), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", 32'(rdy), 32'h1F);
    check("idle_not_busy", 32'(bz), 32'd0);

    // Plain command, num_cks=2
    send(0, 8'hA5, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
    capture(0, 1'b0);
    check("plain_start", se_t, 32'h001);
    check("plain_fire", ef_t, 32'h000);
    check("plain_done", dn_t, 32'h008);
    check("plain_busy", bz_t, 32'h007);
    check("plain_ready", rd_t, 32'hFF8);
    check("plain_te_c0", 32'(te_t[0]), 32'hA5);
    check("plain_te_c2", 32'(te_t[2]), 32'hA5);

    // Change injection, num_cks=4, cycle 2
    send(1, 8'h3C, 1'b1, 1'b0, 3'd2, 4'd0, 1'b0);
    capture(1, 1'b0);
    check("chg_start", se_t, 32'h001);
    check("chg_fire", ef_t, 32'h004);
    check("chg_done", dn_t, 32'h020);
    check("chg_busy", bz_t, 32'h01F);
    check("chg_te_c1", 32'(te_t[1]), 32'h3C);
    check("chg_te_c2", 32'(te_t[2]), 32'hC3);
    check("chg_te_c4", 32'(te_t[4]), 32'hC3);
    check("chg_te_after", 32'(te_t[6]), 32'hC3);

    // Restart with action 1: window extends, restart fires once
    send(2, 8'h5A, 1'b0, 1'b1, 3'd2, 4'd0, 1'b0);
    capture(2, 1'b0);
    check("rst1_start", se_t, 32'h005);
    check("rst1_fire", ef_t, 32'h000);
    check("rst1_done", dn_t, 32'h040);
    check("rst1_busy", bz_t, 32'h03F);

    // Restart with action 2: error expected, window unchanged
    send(3, 8'h5A, 1'b0, 1'b1, 3'd2, 4'd0, 1'b0);
    capture(3, 1'b0);
    check("rst2_start", se_t, 32'h005);
    check("rst2_fire", ef_t, 32'h004);
    check("rst2_done", dn_t, 32'h010);
    check("rst2_busy", bz_t, 32'h00F);

    // Restart with action 0: ignored
    send(4, 8'h5A, 1'b0, 1'b1, 3'd2, 4'd0, 1'b0);
    capture(4, 1'b0);
    check("rst0_start", se_t, 32'h005);
    check("rst0_fire", ef_t, 32'h000);
    check("rst0_done", dn_t, 32'h010);
    check("rst0_busy", bz_t, 32'h00F);

    // Out-of-range injection cycle on num_cks=3 means no injection
    send(4, 8'h81, 1'b1, 1'b1, 3'd0, 4'd0, 1'b0);
    capture(4, 1'b0);
    check("noinj_start", se_t, 32'h001);
    check("noinj_fire", ef_t, 32'h000);
    check("noinj_te_c3", 32'(te_t[3]), 32'h81);

    // Back-to-back with valid held: gap=3 then gap=0
    send(0, 8'h11, 1'b0, 1'b0, 3'd0, 4'd3, 1'b1);
    capture(0, 1'b1);
    vld[0] = 1'b0;
    check("b2b_start", se_t, 32'h081);
    check("b2b_fire", ef_t, 32'h000);
    check("b2b_done", dn_t, 32'h408);
    check("b2b_busy", bz_t, 32'h3BF);
    check("b2b_ready", rd_t, 32'hC40);
    check("b2b_te_gap", 32'(te_t[5]), 32'h11);
    check("b2b_te_second", 32'(te_t[8]), 32'h22);

    // Reset asserted in HOLD cycle 1
    send(0, 8'h66, 1'b0, 1'b0, 3'd0, 4'd1, 1'b0);
    @(posedge clk); #1;
    check("midrst_pre_busy", 32'(bz[0]), 32'd1);
    check("midrst_pre_te", 32'(te[0]), 32'h66);
    reset_n = 1'b0;
    #1;
    check("midrst_te", 32'(te[0]), 32'd0);
    check("midrst_ctrl", 32'({se[0], ef[0], bz[0], dn[0], rdy[0]}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_ready", 32'(rdy[0]), 32'd1);
    send(0, 8'h0F, 1'b0, 1'b0, 3'd0, 4'd1, 1'b0);
    capture(0, 1'b0);
    check("post_start", se_t, 32'h001);
    check("post_done", dn_t, 32'h008);
    check("post_busy", bz_t, 32'h00F);
    check("post_ready", rd_t, 32'hFF0);
    check("post_te_c2", 32'(te_t[2]), 32'h0F);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
